// File: rtl/enemy_patrol_ctrl.sv
// rtl/enemy_patrol_ctrl.sv - patrolling walker enemy with stomp/side-contact detection
// Optional respawn from DEAD is enabled by defining ENEMY_RESPAWN_EN.
module enemy_patrol_ctrl #(
    parameter int X_HOME        = 112,
    parameter int Y_HOME        = 366,
    parameter int RANGE         = 100,
    parameter int STEP          = 1,
    parameter int HIT_W         = 12,
    parameter int HIT_H         = 16,
    parameter int STOMP_MARGIN  = 4,
    parameter int SQUISH_TICKS  = 5,
    parameter int RESPAWN_TICKS = 50
) (
    input  logic       clk_10Hz,
    input  logic       RST_N,
    input  logic [9:0] char_x,
    input  logic [9:0] char_y,
    input  logic       char_falling,
    input  logic [9:0] bg_pos,
    output logic [9:0] enemy_x,
    output logic [9:0] enemy_y,
    output logic       en,
    output logic       squished,
    output logic       death,
    output logic       stomp,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        WALK_L = 2'd0,
        WALK_R = 2'd1,
        SQUISH = 2'd2,
        DEAD   = 2'd3
    } state_t;

    localparam logic [9:0]  X_HOME_C  = 10'(X_HOME);
    localparam logic [9:0]  Y_HOME_C  = 10'(Y_HOME);
    localparam logic [9:0]  STEP_C    = 10'(STEP);
    localparam logic [15:0] RANGE_C   = 16'(RANGE);
    localparam logic [15:0] SQ_LAST   = 16'(SQUISH_TICKS - 1);
    localparam logic [15:0] RESP_LAST = 16'(RESPAWN_TICKS - 1);

    state_t      r_state;
    logic [9:0]  r_world_x;
    logic [15:0] r_leg_cnt;
    logic [15:0] r_timer;
    logic        r_death;
    logic        r_stomp;

    state_t      w_state_nxt;
    logic [9:0]  w_world_x_nxt;
    logic [15:0] w_leg_cnt_nxt;
    logic [15:0] w_timer_nxt;
    logic        w_death_nxt;
    logic        w_stomp_nxt;

    logic [10:0] w_cx, w_cy, w_wx, w_wy;
    logic [10:0] w_dx, w_dy;
    logic        w_overlap;
    logic        w_stomp_ok;

    assign w_cx = {1'b0, char_x};
    assign w_cy = {1'b0, char_y};
    assign w_wx = {1'b0, r_world_x};
    assign w_wy = {1'b0, Y_HOME_C};
    assign w_dx = (w_cx >= w_wx) ? (w_cx - w_wx) : (w_wx - w_cx);
    assign w_dy = (w_cy >= w_wy) ? (w_cy - w_wy) : (w_wy - w_cy);
    assign w_overlap  = (w_dx < 11'(HIT_W)) && (w_dy < 11'(HIT_H));
    // Stomp needs the player's feet no deeper than STOMP_MARGIN into the enemy top.
    assign w_stomp_ok = w_overlap && char_falling &&
                        ((w_cy + 11'(HIT_H)) <= (w_wy + 11'(STOMP_MARGIN)));

    always_ff @(posedge clk_10Hz or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= WALK_L;
            r_world_x <= X_HOME_C;
            r_leg_cnt <= '0;
            r_timer   <= '0;
            r_death   <= 1'b0;
            r_stomp   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_world_x <= w_world_x_nxt;
            r_leg_cnt <= w_leg_cnt_nxt;
            r_timer   <= w_timer_nxt;
            r_death   <= w_death_nxt;
            r_stomp   <= w_stomp_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_world_x_nxt = r_world_x;
        w_leg_cnt_nxt = r_leg_cnt;
        w_timer_nxt   = r_timer;
        w_death_nxt   = 1'b0;
        w_stomp_nxt   = 1'b0;
        case (r_state)
            WALK_L, WALK_R: begin
                if (w_stomp_ok) begin
                    w_state_nxt = SQUISH;
                    w_stomp_nxt = 1'b1;
                    w_timer_nxt = '0;
                end else begin
                    w_death_nxt = w_overlap;
                    if (r_leg_cnt == RANGE_C) begin
                        w_leg_cnt_nxt = '0;
                        w_state_nxt   = (r_state == WALK_L) ? WALK_R : WALK_L;
                    end else begin
                        w_leg_cnt_nxt = r_leg_cnt + 16'd1;
                        w_world_x_nxt = (r_state == WALK_L) ? (r_world_x - STEP_C)
                                                            : (r_world_x + STEP_C);
                    end
                end
            end
            SQUISH: begin
                if (r_timer == SQ_LAST) begin
                    w_state_nxt = DEAD;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            default: begin
`ifdef ENEMY_RESPAWN_EN
                if (r_timer == RESP_LAST) begin
                    w_state_nxt   = WALK_L;
                    w_world_x_nxt = X_HOME_C;
                    w_leg_cnt_nxt = '0;
                    w_timer_nxt   = '0;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
`else
                // Terminal: the timer just saturates so it never wraps.
                if (r_timer != RESP_LAST) begin
                    w_timer_nxt = r_timer + 16'd1;
                end
`endif
            end
        endcase
    end

    always_comb begin
        en       = (r_state != DEAD);
        squished = (r_state == SQUISH);
        state_o  = r_state;
        death    = r_death;
        stomp    = r_stomp;
        enemy_x  = r_world_x - bg_pos;
        enemy_y  = Y_HOME_C;
    end

endmodule
